pccmd_sched: RTL and testbench

PCCMD_SCHED -- requirements
Module: pccmd_sched

---
 rtl/pccmd_sched.sv | 154 +++++++++++++++
 tb/tb_pccmd_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pccmd_sched.sv
// Command scheduler between the host DMA and the PE-array controller.
// Each command is held until the units it depends on are idle, then it is issued.
module pccmd_sched #(
  parameter int AXIS_PCCMD_DATA_WIDTH = 32,
  parameter int AXIS_PCFBK_DATA_WIDTH = 8,
  parameter int STALL_CNT_WIDTH       = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic                             s_axis_inst_tvalid,
  output logic                             s_axis_inst_tready,
  input  logic [AXIS_PCCMD_DATA_WIDTH-1:0] s_axis_inst_tdata,

  output logic                             m_axis_pccmd_tvalid,
  input  logic                             m_axis_pccmd_tready,
  output logic [AXIS_PCCMD_DATA_WIDTH-1:0] m_axis_pccmd_tdata,

  input  logic                             s_axis_pcfbk_tvalid,
  output logic                             s_axis_pcfbk_tready,
  input  logic [AXIS_PCFBK_DATA_WIDTH-1:0] s_axis_pcfbk_tdata,

  output logic [3:0]                       unit_busy,
  output logic                             sched_idle,
  output logic [STALL_CNT_WIDTH-1:0]       stall_cnt,
  output logic                             err_spurious
);

  localparam int LX = 0;
  localparam int LY = 1;
  localparam int EX = 2;
  localparam int ST = 3;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PEND,
    S_ISSUE
  } state_t;

  state_t                           state, state_nxt;
  logic [AXIS_PCCMD_DATA_WIDTH-1:0] cmd_r;
  logic [3:0]                       busy_r;
  logic [3:0]                       busy_set;
  logic [3:0]                       busy_clr;
  logic [3:0]                       cmd_unit;
  logic                             ex_blk_r, ex_xtile_r, ex_ytile_r;
  logic                             hazard;
  logic                             in_hs, out_hs;
  logic                             ready_int, valid_int;
  logic                             unused_fbk_bits;

  assign unused_fbk_bits = ^s_axis_pcfbk_tdata[AXIS_PCFBK_DATA_WIDTH-1:4];

  // Outputs are forced low while reset is held, independent of the registered state.
  assign s_axis_inst_tready  = ready_int & rst_n;
  assign m_axis_pccmd_tvalid = valid_int & rst_n;
  assign m_axis_pccmd_tdata  = cmd_r;
  assign s_axis_pcfbk_tready = 1'b1;
  assign unit_busy           = busy_r;
  assign sched_idle          = (state == S_EMPTY) && (busy_r == '0);

  assign in_hs  = s_axis_inst_tvalid && ready_int;
  assign out_hs = valid_int && m_axis_pccmd_tready;

  // Feedback bit order {loady, loadx, exec, store} remapped onto busy order {ST, EX, LY, LX}.
  assign busy_clr = s_axis_pcfbk_tvalid
                  ? {s_axis_pcfbk_tdata[0], s_axis_pcfbk_tdata[1],
                     s_axis_pcfbk_tdata[3], s_axis_pcfbk_tdata[2]}
                  : '0;
  assign busy_set = out_hs ? cmd_unit : '0;

  always_comb begin
    hazard = 1'b0;
    if (cmd_r[2]) begin
      hazard = busy_r[EX] | busy_r[LX] | busy_r[LY];
    end else begin
      case (cmd_r[1:0])
        2'b00: hazard = |busy_r;
        2'b01: begin
          if (cmd_r[3])
            hazard = busy_r[LY] | (busy_r[EX] & ex_blk_r & (ex_ytile_r == cmd_r[4]));
          else
            hazard = busy_r[LX] | (busy_r[EX] & ex_blk_r & (ex_xtile_r == cmd_r[4]));
        end
        2'b10:   hazard = busy_r[LX] | busy_r[EX];
        default: hazard = busy_r[ST] | busy_r[EX];
      endcase
    end
  end

  always_comb begin
    cmd_unit = '0;
    if (cmd_r[2]) begin
      cmd_unit[EX] = 1'b1;
    end else begin
      case (cmd_r[1:0])
        2'b01: begin
          if (cmd_r[3]) cmd_unit[LY] = 1'b1;
          else          cmd_unit[LX] = 1'b1;
        end
        2'b10:   cmd_unit[LX] = 1'b1;
        2'b11:   cmd_unit[ST] = 1'b1;
        default: cmd_unit = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ready_int = 1'b0;
    valid_int = 1'b0;
    case (state)
      S_EMPTY: begin
        ready_int = 1'b1;
        if (s_axis_inst_tvalid) state_nxt = S_PEND;
      end
      S_PEND: begin
        if (!hazard) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        valid_int = 1'b1;
        if (m_axis_pccmd_tready) state_nxt = S_EMPTY;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_EMPTY;
      cmd_r        <= '0;
      busy_r       <= '0;
      ex_blk_r     <= 1'b0;
      ex_xtile_r   <= 1'b0;
      ex_ytile_r   <= 1'b0;
      stall_cnt    <= '0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_hs) cmd_r <= s_axis_inst_tdata;
      // A set overrides a clear of the same unit in the same cycle.
      busy_r <= (busy_r & ~busy_clr) | busy_set;
      if (out_hs && cmd_r[2]) begin
        ex_blk_r   <= (cmd_r[2:0] == 3'b100);
        ex_xtile_r <= cmd_r[17];
        ex_ytile_r <= cmd_r[18];
      end
      if ((state == S_PEND) && hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
      if (|(busy_clr & ~busy_r)) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pccmd_sched.sv
// Directed bench for pccmd_sched: a rule-level reference model checked every
// cycle, plus literal checks for the key latency, hazard and reset scenarios.
module tb_pccmd_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_axis_inst_tvalid;
  logic        s_axis_inst_tready;
  logic [31:0] s_axis_inst_tdata;
  logic        m_axis_pccmd_tvalid;
  logic        m_axis_pccmd_tready;
  logic [31:0] m_axis_pccmd_tdata;
  logic        s_axis_pcfbk_tvalid;
  logic        s_axis_pcfbk_tready;
  logic [7:0]  s_axis_pcfbk_tdata;
  logic [3:0]  unit_busy;
  logic        sched_idle;
  logic [15:0] stall_cnt;
  logic        err_spurious;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pccmd_sched #(
    .AXIS_PCCMD_DATA_WIDTH(32),
    .AXIS_PCFBK_DATA_WIDTH(8),
    .STALL_CNT_WIDTH(16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_inst_tvalid  (s_axis_inst_tvalid),
    .s_axis_inst_tready  (s_axis_inst_tready),
    .s_axis_inst_tdata   (s_axis_inst_tdata),
    .m_axis_pccmd_tvalid (m_axis_pccmd_tvalid),
    .m_axis_pccmd_tready (m_axis_pccmd_tready),
    .m_axis_pccmd_tdata  (m_axis_pccmd_tdata),
    .s_axis_pcfbk_tvalid (s_axis_pcfbk_tvalid),
    .s_axis_pcfbk_tready (s_axis_pcfbk_tready),
    .s_axis_pcfbk_tdata  (s_axis_pcfbk_tdata),
    .unit_busy           (unit_busy),
    .sched_idle          (sched_idle),
    .stall_cnt           (stall_cnt),
    .err_spurious        (err_spurious)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Busy vector uses the output order: [0]=LX [1]=LY [2]=EX [3]=ST.
  bit          chk_en = 1'b0;
  bit          md_have, md_ok;
  logic [31:0] md_cmd;
  bit   [3:0]  md_busy;
  bit          md_blk, md_xt, md_yt, md_err;
  int unsigned md_stall;

  function automatic bit md_hazard(logic [31:0] c, bit [3:0] b, bit blk, bit xt, bit yt);
    bit lx, ly, ex, st;
    lx = b[0]; ly = b[1]; ex = b[2]; st = b[3];
    if (c[2])               return ex || lx || ly;
    if (c[1:0] == 2'b00)    return b != 4'b0;
    if (c[1:0] == 2'b10)    return lx || ex;
    if (c[1:0] == 2'b11)    return st || ex;
    if (c[3])               return ly || (ex && blk && (yt == c[4]));
    return lx || (ex && blk && (xt == c[4]));
  endfunction

  function automatic bit [3:0] md_unit(logic [31:0] c);
    if (c[2])            return 4'b0100;
    if (c[1:0] == 2'b01) return c[3] ? 4'b0010 : 4'b0001;
    if (c[1:0] == 2'b10) return 4'b0001;
    if (c[1:0] == 2'b11) return 4'b1000;
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    bit [3:0] b, set, clr;
    if (!rst_n) begin
      chk_en = 1'b1;
      md_have = 0; md_ok = 0; md_cmd = '0; md_busy = '0;
      md_blk = 0; md_xt = 0; md_yt = 0; md_err = 0; md_stall = 0;
    end else begin
      b = md_busy; set = '0; clr = '0;
      if (!md_have) begin
        if (s_axis_inst_tvalid) begin md_have = 1; md_ok = 0; md_cmd = s_axis_inst_tdata; end
      end else if (!md_ok) begin
        if (md_hazard(md_cmd, b, md_blk, md_xt, md_yt)) begin
          if (md_stall < 32'hFFFF) md_stall++;
        end else md_ok = 1;
      end else if (m_axis_pccmd_tready) begin
        md_have = 0;
        set = md_unit(md_cmd);
        if (md_cmd[2]) begin
          md_blk = (md_cmd[2:0] == 3'b100); md_xt = md_cmd[17]; md_yt = md_cmd[18];
        end
      end
      if (s_axis_pcfbk_tvalid) begin
        if (s_axis_pcfbk_tdata[0]) clr[3] = 1;
        if (s_axis_pcfbk_tdata[1]) clr[2] = 1;
        if (s_axis_pcfbk_tdata[2]) clr[0] = 1;
        if (s_axis_pcfbk_tdata[3]) clr[1] = 1;
      end
      for (int u = 0; u < 4; u++) if (clr[u] && !b[u]) md_err = 1;
      md_busy = (b & ~clr) | set;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("inst_tready", {31'b0, s_axis_inst_tready}, {31'b0, rst_n && !md_have});
      chk("pccmd_tvalid", {31'b0, m_axis_pccmd_tvalid}, {31'b0, rst_n && md_have && md_ok});
      if (rst_n && md_have && md_ok) chk("pccmd_tdata", m_axis_pccmd_tdata, md_cmd);
      chk("unit_busy", {28'b0, unit_busy}, {28'b0, md_busy});
      chk("sched_idle", {31'b0, sched_idle}, {31'b0, !md_have && md_busy == 0});
      chk("stall_cnt", {16'b0, stall_cnt}, md_stall);
      chk("err_spurious", {31'b0, err_spurious}, {31'b0, md_err});
      chk("pcfbk_tready", {31'b0, s_axis_pcfbk_tready}, 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_inst(input logic [31:0] d);
    bit ok = 0;
    int unsigned n = 0;
    s_axis_inst_tvalid = 1'b1;
    s_axis_inst_tdata  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_axis_inst_tready;
      @(posedge clk); #1;
      n++;
    end
    s_axis_inst_tvalid = 1'b0;
    chk("inst_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_tvalid(input int unsigned lim);
    bit seen = 0;
    for (int unsigned i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = m_axis_pccmd_tvalid;
    end
    chk("tvalid_arrives", {31'b0, seen}, 32'd1);
  endtask

  task automatic fbk(input logic [7:0] d);
    s_axis_pcfbk_tvalid = 1'b1;
    s_axis_pcfbk_tdata  = d;
    @(posedge clk); #1;
    s_axis_pcfbk_tvalid = 1'b0;
    s_axis_pcfbk_tdata  = '0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis_inst_tvalid = 1'b0; s_axis_inst_tdata = '0;
    m_axis_pccmd_tready = 1'b1;
    s_axis_pcfbk_tvalid = 1'b0; s_axis_pcfbk_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {31'b0, m_axis_pccmd_tvalid}, 32'd0);
    chk("rst_tready", {31'b0, s_axis_inst_tready}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {31'b0, sched_idle}, 32'd1);
    chk("busy_after_rst", {28'b0, unit_busy}, 32'd0);
    step();

    // Single load X: tvalid two cycles after the input handshake.
    send_inst(32'h0000_0001);
    @(negedge clk); chk("lx_cyc1_tvalid", {31'b0, m_axis_pccmd_tvalid}, 32'd0);
    @(negedge clk); chk("lx_cyc2_tvalid", {31'b0, m_axis_pccmd_tvalid}, 32'd1);
    chk("lx_tdata", m_axis_pccmd_tdata, 32'h0000_0001);
    @(negedge clk); chk("lx_busy", {28'b0, unit_busy}, 32'h1);
    step(); fbk(8'h04);
    @(negedge clk); chk("lx_cleared", {28'b0, unit_busy}, 32'h0);
    chk("lx_idle", {31'b0, sched_idle}, 32'd1);
    step();

    // No tile conflict: exec blk xtile=0, then load X tile 1 issues without stall.
    send_inst(32'h0000_0004); wait_tvalid(10); step();
    send_inst(32'h0000_0011);
    @(negedge clk); @(negedge clk);
    chk("noconf_tvalid", {31'b0, m_axis_pccmd_tvalid}, 32'd1);
    chk("noconf_stall", {16'b0, stall_cnt}, 32'd0);
    step(); fbk(8'h06);
    @(negedge clk); chk("noconf_clr", {28'b0, unit_busy}, 32'h0);
    step();

    // Tile conflict: exec blk xtile=1, then load X tile 1 stalls until EX done.
    send_inst(32'h0002_0004); wait_tvalid(10); step();
    send_inst(32'h0000_0011);
    repeat (6) @(negedge clk);
    chk("conf_held", {31'b0, m_axis_pccmd_tvalid}, 32'd0);
    chk("conf_stall5", {16'b0, stall_cnt}, 32'd5);
    step(); fbk(8'h02);
    @(negedge clk); chk("conf_not_yet", {31'b0, m_axis_pccmd_tvalid}, 32'd0);
    @(negedge clk); chk("conf_issue", {31'b0, m_axis_pccmd_tvalid}, 32'd1);
    chk("conf_stall7", {16'b0, stall_cnt}, 32'd7);
    step(); fbk(8'h04);
    @(negedge clk); chk("conf_clr", {28'b0, unit_busy}, 32'h0);
    step();

    // Store behind exec.
    send_inst(32'h0000_0004); wait_tvalid(10); step();
    send_inst(32'h0000_0003);
    repeat (3) @(negedge clk);
    chk("st_held", {31'b0, m_axis_pccmd_tvalid}, 32'd0);
    step(); fbk(8'h02); wait_tvalid(10); step();
    @(negedge clk); chk("st_busy", {28'b0, unit_busy}, 32'h8);
    step(); fbk(8'h01);
    @(negedge clk); chk("st_clr", {28'b0, unit_busy}, 32'h0);
    step();

    // Spurious feedback, then backpressure in ISSUE.
    fbk(8'h08);
    @(negedge clk); chk("spurious", {31'b0, err_spurious}, 32'd1);
    step();
    m_axis_pccmd_tready = 1'b0;
    send_inst(32'hABCD_0000); wait_tvalid(10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_tvalid", {31'b0, m_axis_pccmd_tvalid}, 32'd1);
      chk("bp_tdata", m_axis_pccmd_tdata, 32'hABCD_0000);
      @(negedge clk);
    end
    step(); m_axis_pccmd_tready = 1'b1;
    step();

    // Saturating stall counter, then reset while a command sits in ISSUE.
    send_inst(32'h0000_0004); wait_tvalid(10); step();
    send_inst(32'h0000_0003);
    repeat (65540) @(posedge clk);
    @(negedge clk); chk("stall_sat", {16'b0, stall_cnt}, 32'hFFFF);
    step();
    m_axis_pccmd_tready = 1'b0;
    fbk(8'h02); wait_tvalid(10);
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_issue_tvalid", {31'b0, m_axis_pccmd_tvalid}, 32'd0);
    chk("rst_issue_tready", {31'b0, s_axis_inst_tready}, 32'd0);
    step();
    @(negedge clk); chk("rst_issue_busy", {28'b0, unit_busy}, 32'h0);
    step(); rst_n = 1'b1; m_axis_pccmd_tready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'b0, sched_idle}, 32'd1);
    chk("post_rst_stall", {16'b0, stall_cnt}, 32'd0);
    chk("post_rst_err", {31'b0, err_spurious}, 32'd0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
